// File: rtl/scr1_pipe_mprf_mp_pkg.sv
// Shared arch types for the multi-port register file and its pending-write scoreboard.
// Same-cycle write-to-read bypass is enabled by defining SCR1_MPRF_BYPASS_EN.
package scr1_pipe_mprf_mp_pkg;

  localparam int unsigned SCR1_XLEN       = 32;
  localparam int unsigned SCR1_MPRF_NREGS = 32;
  localparam int unsigned SCR1_MPRF_NRP   = 2;

  typedef logic [SCR1_XLEN-1:0] type_scr1_mprf_v;

endpackage

// File: rtl/scr1_pipe_mprf_mp_sb.sv
// Pending-write scoreboard: one bit per register, set by reservations and
// cleared by long-latency writeback or a pipeline flush.
module scr1_pipe_mprf_sb
  import scr1_pipe_mprf_mp_pkg::*;
#(
  parameter int unsigned NREGS = SCR1_MPRF_NREGS,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rsv_req,
  input  logic [AW-1:0]        i_rsv_addr,
  input  logic                 i_clr_req,
  input  logic [AW-1:0]        i_clr_addr,
  input  logic                 i_flush,
  output logic                 o_rsv_rdy,
  output logic [(2**AW)-1:0]   o_pending
);

  localparam int unsigned NSLOTS = 2**AW;

  logic [NSLOTS-1:0] r_pending;
  logic [NSLOTS-1:0] w_pending_nxt;
  logic              w_rsv_acc;

  assign o_rsv_rdy = ~r_pending[i_rsv_addr];
  assign w_rsv_acc = i_rsv_req & o_rsv_rdy & (i_rsv_addr != '0)
                   & (32'(i_rsv_addr) < NREGS);

  // An accepted reservation wins over a same-cycle clear; flush wins over both.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_flush) begin
      w_pending_nxt = '0;
    end else begin
      if (i_clr_req) w_pending_nxt[i_clr_addr] = 1'b0;
      if (w_rsv_acc) w_pending_nxt[i_rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/scr1_pipe_mprf_mp.sv
// Multi-port register file with EXU/LSU write ports and pending-write scoreboard.
// Optional same-cycle bypass of write data to read ports: SCR1_MPRF_BYPASS_EN.
module scr1_pipe_mprf_mp
  import scr1_pipe_mprf_mp_pkg::*;
#(
  parameter int unsigned XLEN  = SCR1_XLEN,
  parameter int unsigned NREGS = SCR1_MPRF_NREGS,
  parameter int unsigned NRP   = SCR1_MPRF_NRP
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NRP-1:0][$clog2(NREGS)-1:0]      rp_addr,
  output logic [NRP-1:0][XLEN-1:0]               rp_data,
  output logic [NRP-1:0]                         rp_busy,
  input  logic                                   w0_req,
  input  logic [$clog2(NREGS)-1:0]               w0_addr,
  input  logic [XLEN-1:0]                        w0_data,
  input  logic                                   w1_req,
  input  logic [$clog2(NREGS)-1:0]               w1_addr,
  input  logic [XLEN-1:0]                        w1_data,
  input  logic                                   rsv_req,
  input  logic [$clog2(NREGS)-1:0]               rsv_addr,
  output logic                                   rsv_rdy,
  input  logic                                   sb_flush
);

  localparam int unsigned AW     = $clog2(NREGS);
  localparam int unsigned NSLOTS = 2**AW;

  logic [XLEN-1:0]   w_regs [NSLOTS];
  logic [NSLOTS-1:0] w_pending;

  // x0 and slots beyond NREGS are hard zero; w0 wins over w1 on collisions.
  for (genvar g = 0; g < int'(NSLOTS); g++) begin : g_reg
    if (g == 0 || g >= int'(NREGS)) begin : g_zero
      assign w_regs[g] = '0;
    end else begin : g_live
      logic [XLEN-1:0] r_val;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               r_val <= '0;
        else if (w0_req && (w0_addr == AW'(g)))   r_val <= w0_data;
        else if (w1_req && (w1_addr == AW'(g)))   r_val <= w1_data;
      end
      assign w_regs[g] = r_val;
    end
  end

  scr1_pipe_mprf_sb #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rsv_req  (rsv_req),
    .i_rsv_addr (rsv_addr),
    .i_clr_req  (w1_req),
    .i_clr_addr (w1_addr),
    .i_flush    (sb_flush),
    .o_rsv_rdy  (rsv_rdy),
    .o_pending  (w_pending)
  );

  for (genvar p = 0; p < int'(NRP); p++) begin : g_rp
`ifdef SCR1_MPRF_BYPASS_EN
    logic w_addr_ok;
    logic w_w0_hit;
    logic w_w1_hit;
    assign w_addr_ok = (rp_addr[p] != '0) && (32'(rp_addr[p]) < NREGS);
    assign w_w0_hit  = rst_n & w0_req & w_addr_ok & (w0_addr == rp_addr[p]);
    assign w_w1_hit  = rst_n & w1_req & w_addr_ok & (w1_addr == rp_addr[p]);
    assign rp_data[p] = w_w0_hit ? w0_data :
                        w_w1_hit ? w1_data : w_regs[rp_addr[p]];
    assign rp_busy[p] = w_pending[rp_addr[p]] & ~w_w1_hit;
`else
    assign rp_data[p] = w_regs[rp_addr[p]];
    assign rp_busy[p] = w_pending[rp_addr[p]];
`endif
  end

`ifndef SYNTHESIS
  a_w0_known: assert property (@(posedge clk) disable iff (!rst_n)
    w0_req |-> !$isunknown({w0_addr, w0_data}))
    else $error("w0 write with unknown address or data");
  a_w1_known: assert property (@(posedge clk) disable iff (!rst_n)
    w1_req |-> !$isunknown({w1_addr, w1_data}))
    else $error("w1 write with unknown address or data");
`endif

endmodule

// File: tb/tb_scr1_pipe_mprf_mp.sv
// Self-checking bench for scr1_pipe_mprf_mp: directed scenarios plus randomized
// traffic against a behavioural register/pending model.
module tb_scr1_pipe_mprf_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRP   = 2;
  localparam int unsigned AW    = 5;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NRP-1:0][AW-1:0]     rp_addr;
  logic [NRP-1:0][XLEN-1:0]   rp_data;
  logic [NRP-1:0]             rp_busy;
  logic                       w0_req, w1_req, rsv_req, sb_flush;
  logic [AW-1:0]              w0_addr, w1_addr, rsv_addr;
  logic [XLEN-1:0]            w0_data, w1_data;
  logic                       rsv_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_pend [NREGS];

  always #5 clk = ~clk;

  scr1_pipe_mprf_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP)) dut (
    .clk(clk), .rst_n(rst_n),
    .rp_addr(rp_addr), .rp_data(rp_data), .rp_busy(rp_busy),
    .w0_req(w0_req), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_req(w1_req), .w1_addr(w1_addr), .w1_data(w1_data),
    .rsv_req(rsv_req), .rsv_addr(rsv_addr), .rsv_rdy(rsv_rdy),
    .sb_flush(sb_flush)
  );

  task automatic model_clear();
    for (int i = 0; i < int'(NREGS); i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge with the current inputs.
  task automatic model_edge();
    bit rdy;
    rdy = !m_pend[rsv_addr];
    if (w1_req && w1_addr != 0) m_regs[w1_addr] = w1_data;
    if (w0_req && w0_addr != 0) m_regs[w0_addr] = w0_data;
    if (sb_flush) begin
      for (int i = 0; i < int'(NREGS); i++) m_pend[i] = 1'b0;
    end else begin
      if (w1_req) m_pend[w1_addr] = 1'b0;
      if (rsv_req && rdy && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
    end
  endtask

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef SCR1_MPRF_BYPASS_EN
    if (rst_n && w0_req && w0_addr == a) return w0_data;
    if (rst_n && w1_req && w1_addr == a) return w1_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef SCR1_MPRF_BYPASS_EN
    if (rst_n && w1_req && w1_addr == a) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  task automatic set_idle();
    w0_req = 0; w0_addr = '0; w0_data = '0;
    w1_req = 0; w1_addr = '0; w1_data = '0;
    rsv_req = 0; rsv_addr = '0; sb_flush = 0;
    rp_addr = '0;
  endtask

  task automatic tick();
    if (rst_n) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    set_idle();
    w0_req = 1; w0_addr = 5; w0_data = 32'hFFFF_FFFF;
    rsv_req = 1; rsv_addr = 5;
    rp_addr[0] = 0; rp_addr[1] = 5;
    #1;
    n_tests++; if (rp_data[0] !== '0) begin n_fail++; $display("FAIL rst_x0_data got=%h exp=0", rp_data[0]); end
    n_tests++; if (rp_data[1] !== '0) begin n_fail++; $display("FAIL rst_x5_data got=%h exp=0", rp_data[1]); end
    n_tests++; if (rp_busy !== 2'b00) begin n_fail++; $display("FAIL rst_busy got=%b exp=00", rp_busy); end
    n_tests++; if (rsv_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rsv_rdy got=%b exp=1", rsv_rdy); end
    tick();
    rst_n = 1'b1;
    set_idle();
    rp_addr[0] = 5; rp_addr[1] = 0; rsv_addr = 5;
    #1;
    n_tests++; if (rp_data[0] !== '0) begin n_fail++; $display("FAIL post_rst_x5_data got=%h exp=0", rp_data[0]); end
    n_tests++; if (rp_data[1] !== '0) begin n_fail++; $display("FAIL post_rst_x0_data got=%h exp=0", rp_data[1]); end
    n_tests++; if (rp_busy !== 2'b00) begin n_fail++; $display("FAIL post_rst_busy got=%b exp=00", rp_busy); end
    n_tests++; if (rsv_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_rsv_rdy got=%b exp=1", rsv_rdy); end
  endtask

  task automatic test_w0_priority();
    set_idle();
    w0_req = 1; w0_addr = 3; w0_data = 32'hDEAD_BEEF;
    w1_req = 1; w1_addr = 3; w1_data = 32'h1234_5678;
    tick();
    set_idle();
    rp_addr[0] = 3; rp_addr[1] = 3;
    #1;
    n_tests++; if (rp_data[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL prio_p0 got=%h exp=deadbeef", rp_data[0]); end
    n_tests++; if (rp_data[1] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL prio_p1 got=%h exp=deadbeef", rp_data[1]); end
    n_tests++; if (rp_busy !== 2'b00) begin n_fail++; $display("FAIL prio_busy got=%b exp=00", rp_busy); end
  endtask

  task automatic test_reserve();
    set_idle();
    rsv_req = 1; rsv_addr = 7;
    #1;
    n_tests++; if (rsv_rdy !== 1'b1) begin n_fail++; $display("FAIL rsv_rdy_free got=%b exp=1", rsv_rdy); end
    tick();
    set_idle();
    rsv_addr = 7; rp_addr[1] = 7;
    #1;
    n_tests++; if (rsv_rdy !== 1'b0) begin n_fail++; $display("FAIL rsv_rdy_pend got=%b exp=0", rsv_rdy); end
    n_tests++; if (rp_busy[1] !== 1'b1) begin n_fail++; $display("FAIL rsv_busy got=%b exp=1", rp_busy[1]); end
    // Refused re-reservation must not keep x7 pending across the writeback.
    rsv_req = 1; w1_req = 1; w1_addr = 7; w1_data = 32'h55;
    #1;
`ifdef SCR1_MPRF_BYPASS_EN
    n_tests++; if (rp_busy[1] !== 1'b0) begin n_fail++; $display("FAIL wb_byp_busy got=%b exp=0", rp_busy[1]); end
    n_tests++; if (rp_data[1] !== 32'h55) begin n_fail++; $display("FAIL wb_byp_data got=%h exp=55", rp_data[1]); end
`else
    n_tests++; if (rp_busy[1] !== 1'b1) begin n_fail++; $display("FAIL wb_nobyp_busy got=%b exp=1", rp_busy[1]); end
    n_tests++; if (rp_data[1] !== 32'h0) begin n_fail++; $display("FAIL wb_nobyp_data got=%h exp=0", rp_data[1]); end
`endif
    tick();
    set_idle();
    rsv_addr = 7; rp_addr[1] = 7;
    #1;
    n_tests++; if (rp_busy[1] !== 1'b0) begin n_fail++; $display("FAIL wb_busy got=%b exp=0", rp_busy[1]); end
    n_tests++; if (rp_data[1] !== 32'h55) begin n_fail++; $display("FAIL wb_data got=%h exp=55", rp_data[1]); end
    n_tests++; if (rsv_rdy !== 1'b1) begin n_fail++; $display("FAIL wb_rsv_rdy got=%b exp=1", rsv_rdy); end
  endtask

  task automatic test_rsv_race_flush();
    set_idle();
    w1_req = 1; w1_addr = 9; w1_data = 32'h99;
    rsv_req = 1; rsv_addr = 9;
    tick();
    set_idle();
    rp_addr[0] = 9; rsv_addr = 9;
    #1;
    n_tests++; if (rp_busy[0] !== 1'b1) begin n_fail++; $display("FAIL race_busy got=%b exp=1", rp_busy[0]); end
    n_tests++; if (rp_data[0] !== 32'h99) begin n_fail++; $display("FAIL race_data got=%h exp=99", rp_data[0]); end
    n_tests++; if (rsv_rdy !== 1'b0) begin n_fail++; $display("FAIL race_rsv_rdy got=%b exp=0", rsv_rdy); end
    set_idle();
    rsv_req = 1; rsv_addr = 10;
    tick();
    set_idle();
    sb_flush = 1; rsv_req = 1; rsv_addr = 11;
    tick();
    set_idle();
    rp_addr[0] = 9; rp_addr[1] = 10; rsv_addr = 11;
    #1;
    n_tests++; if (rp_busy !== 2'b00) begin n_fail++; $display("FAIL flush_busy got=%b exp=00", rp_busy); end
    n_tests++; if (rp_data[0] !== 32'h99) begin n_fail++; $display("FAIL flush_data got=%h exp=99", rp_data[0]); end
    n_tests++; if (rsv_rdy !== 1'b1) begin n_fail++; $display("FAIL flush_rsv_rdy got=%b exp=1", rsv_rdy); end
  endtask

  task automatic test_bypass();
    set_idle();
    w0_req = 1; w0_addr = 4; w0_data = 32'h1111_1111;
    rsv_req = 1; rsv_addr = 4;
    tick();
    set_idle();
    rp_addr[0] = 4;
    #1;
    n_tests++; if (rp_busy[0] !== 1'b1) begin n_fail++; $display("FAIL byp_pre_busy got=%b exp=1", rp_busy[0]); end
    n_tests++; if (rp_data[0] !== 32'h1111_1111) begin n_fail++; $display("FAIL byp_pre_data got=%h exp=11111111", rp_data[0]); end
    w1_req = 1; w1_addr = 4; w1_data = 32'hA5A5_A5A5;
    #1;
`ifdef SCR1_MPRF_BYPASS_EN
    n_tests++; if (rp_data[0] !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL byp_data got=%h exp=a5a5a5a5", rp_data[0]); end
    n_tests++; if (rp_busy[0] !== 1'b0) begin n_fail++; $display("FAIL byp_busy got=%b exp=0", rp_busy[0]); end
`else
    n_tests++; if (rp_data[0] !== 32'h1111_1111) begin n_fail++; $display("FAIL nobyp_data got=%h exp=11111111", rp_data[0]); end
    n_tests++; if (rp_busy[0] !== 1'b1) begin n_fail++; $display("FAIL nobyp_busy got=%b exp=1", rp_busy[0]); end
`endif
    tick();
    set_idle();
    rp_addr[0] = 4;
    #1;
    n_tests++; if (rp_data[0] !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL byp_post_data got=%h exp=a5a5a5a5", rp_data[0]); end
    n_tests++; if (rp_busy[0] !== 1'b0) begin n_fail++; $display("FAIL byp_post_busy got=%b exp=0", rp_busy[0]); end
  endtask

  task automatic test_reset_mid();
    set_idle();
    w0_req = 1; w0_addr = 2; w0_data = 32'h1;
    rsv_req = 1; rsv_addr = 2;
    tick();
    set_idle();
    rp_addr[1] = 2; rsv_addr = 2;
    #1;
    n_tests++; if (rp_data[1] !== 32'h1) begin n_fail++; $display("FAIL mid_pre_data got=%h exp=1", rp_data[1]); end
    n_tests++; if (rp_busy[1] !== 1'b1) begin n_fail++; $display("FAIL mid_pre_busy got=%b exp=1", rp_busy[1]); end
    rsv_req = 1;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_tests++; if (rp_data[1] !== '0) begin n_fail++; $display("FAIL mid_rst_data got=%h exp=0", rp_data[1]); end
    n_tests++; if (rp_busy[1] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", rp_busy[1]); end
    n_tests++; if (rsv_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_rst_rsv_rdy got=%b exp=1", rsv_rdy); end
    tick();
    rst_n = 1'b1;
    set_idle();
    rp_addr[1] = 2;
    #1;
    n_tests++; if (rp_busy[1] !== 1'b0) begin n_fail++; $display("FAIL mid_post_busy got=%b exp=0", rp_busy[1]); end
    n_tests++; if (rp_data[1] !== '0) begin n_fail++; $display("FAIL mid_post_data got=%h exp=0", rp_data[1]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      w0_req   = 1'($urandom_range(0, 1));
      w0_addr  = AW'($urandom_range(0, 7));
      w0_data  = $urandom();
      w1_req   = 1'($urandom_range(0, 1));
      w1_addr  = AW'($urandom_range(0, 7));
      w1_data  = $urandom();
      rsv_req  = 1'($urandom_range(0, 1));
      rsv_addr = AW'($urandom_range(0, 7));
      sb_flush = ($urandom_range(0, 15) == 0);
      rp_addr[0] = AW'($urandom_range(0, 7));
      rp_addr[1] = AW'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < int'(NRP); p++) begin
        n_tests++;
        if (rp_data[p] !== exp_data(rp_addr[p])) begin
          n_fail++;
          $display("FAIL rnd_data c=%0d p=%0d a=%0d got=%h exp=%h", c, p, rp_addr[p], rp_data[p], exp_data(rp_addr[p]));
        end
        n_tests++;
        if (rp_busy[p] !== exp_busy(rp_addr[p])) begin
          n_fail++;
          $display("FAIL rnd_busy c=%0d p=%0d a=%0d got=%b exp=%b", c, p, rp_addr[p], rp_busy[p], exp_busy(rp_addr[p]));
        end
      end
      n_tests++;
      if (rsv_rdy !== !m_pend[rsv_addr]) begin
        n_fail++;
        $display("FAIL rnd_rsv_rdy c=%0d a=%0d got=%b exp=%b", c, rsv_addr, rsv_rdy, !m_pend[rsv_addr]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_w0_priority();
    test_reserve();
    test_rsv_race_flush();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scr1_pipe_mprf_mp.md
SCR1_PIPE_MPRF_MP -- requirements
Module: scr1_pipe_mprf_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter NREGS, default 32 (16 for RVE builds), register count including x0.
REQ-003 SHALL have parameter NRP, default 2, number of read ports (1..4).
REQ-004 SHALL derive AW = $clog2(NREGS) as a localparam.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port rp_addr, input, NRP x AW, read addresses.
REQ-008 SHALL have port rp_data, output, NRP x XLEN, read data.
REQ-009 SHALL have port rp_busy, output, NRP, read target pending.
REQ-010 SHALL have ports w0_req/w0_addr/w0_data, inputs, 1/AW/XLEN, single-cycle EXU write port.
REQ-011 SHALL have ports w1_req/w1_addr/w1_data, inputs, 1/AW/XLEN, long-latency (LSU/MDU) writeback port.
REQ-012 SHALL have ports rsv_req/rsv_addr, inputs, 1/AW, reserve a register as pending.
REQ-013 SHALL have port rsv_rdy, output, 1; high when rsv_addr is not currently pending.
REQ-014 SHALL have port sb_flush, input, 1, clear all pending bits (pipeline kill).

Function
REQ-015 SHALL read combinationally; address 0 SHALL return 0 with rp_busy=0.
REQ-016 SHALL write w0 and w1 on the rising clk edge; a write to address 0 SHALL be ignored.
REQ-017 SHALL give w0 priority over w1 when both target the same non-zero address in the same cycle.
REQ-018 SHALL set pending[a] on the edge when rsv_req & rsv_rdy & a!=0; a reservation with rsv_rdy=0 SHALL be ignored.
REQ-019 SHALL clear pending[a] on the edge when w1_req & w1_addr==a, unless a same-cycle accepted reservation targets a (pending stays set).
REQ-020 SHALL let sb_flush clear all pending bits on the edge, overriding same-cycle reservations; register contents SHALL be unaffected.
REQ-021 SHALL drive rp_busy[i] = pending[rp_addr[i]] from registered state (before bypass).
REQ-022 SHALL perform a w1 write to a non-pending register normally, leaving pending unchanged.
REQ-023 SHALL handle addresses >= NREGS (non-power-of-two NREGS) as no-write, read 0.

Reset
REQ-024 SHALL clear all pending bits asynchronously on rst_n low; rsv_rdy SHALL be 1 and rp_busy 0 during reset.
REQ-025 SHALL clear registers x1..x(NREGS-1) to 0 on reset; writes and reservations during reset SHALL be ignored.

Configuration
REQ-026 SHALL support macro SCR1_MPRF_BYPASS_EN.
REQ-027 With SCR1_MPRF_BYPASS_EN: rp_data[i] SHALL return same-cycle w0 data (else w1 data) when the port write targets rp_addr[i]!=0, and rp_busy[i] SHALL be 0 if w1 writes that address in the same cycle.
REQ-028 Without SCR1_MPRF_BYPASS_EN: rp_data SHALL return pre-edge stored value; rp_busy per REQ-021 only.

Structure
REQ-029 SHALL take XLEN/NREGS defaults and the register-vector type from the shared arch-types package.
REQ-030 SHALL place pending-bit logic in sub-module scr1_pipe_mprf_sb (NREGS, AW parameters).
REQ-031 SHALL include a simulation-only assertion flagging unknown w0/w1 address or data when the write request is asserted.

Verification
REQ-032 Reset, then read x0 and x5 on both ports -> data 0, busy 0, rsv_rdy 1.
REQ-033 w0 writes x3=0xDEADBEEF and w1 writes x3=0x12345678 same cycle -> next cycle x3 reads 0xDEADBEEF.
REQ-034 Reserve x7; next cycle rsv_addr=x7 -> rsv_rdy 0, rp_busy for x7 = 1; w1 writes x7=0x55 -> following cycle busy 0, data 0x55.
REQ-035 w1 clears x9 while rsv_req re-reserves x9 same cycle -> x9 remains pending; sb_flush -> all pending 0, data preserved.
REQ-036 With SCR1_MPRF_BYPASS_EN, read x4 while w1 writes x4=0xA5A5A5A5 -> same-cycle rp_data 0xA5A5A5A5, busy 0; without macro -> old value.
REQ-037 Assert rst_n low mid-reservation with x2 pending and x2=0x1 -> x2 reads 0, pending cleared immediately.
